// File: rtl/ddr_axi4_arb_pkg.sv
// Shared FSM state type, AXI encodings and a width helper for the DDR AXI4 write master.
package ddr_axi4_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 32'sd1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ddr_wr_data_fifo.sv
// Synchronous write-data buffer; the head entry is read combinationally so a push
// becomes visible at the output one cycle later.
module ddr_wr_data_fifo
  import ddr_axi4_arb_pkg::*;
#(
  parameter int DW    = 512,
  parameter int DEPTH = 256
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int PW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == CW'(0));
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointer wrap and occupancy update; simultaneous push and pop keep the level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset; emptiness is tracked by the counters alone.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ddr_axi4_write_master.sv
// AXI4 write master: one burst outstanding, AW then buffered W beats then B.
// Define AXI_WR_RESP_CHK_EN to flag non-OKAY BRESP or foreign BID on a sticky err_o.
module ddr_axi4_write_master
  import ddr_axi4_arb_pkg::*;
#(
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH = 512,
  parameter int          AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ID         = 32'd0,
  parameter int          FIFO_DEPTH     = 256
) (
  input  logic                          sys_clk_i,
  input  logic                          reset_i,
  input  logic                          req_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     wstart_addr_i,
  input  logic [7:0]                    burst_size_i,
  input  logic [AXI_DATA_WIDTH-1:0]     data_i,
  input  logic                          data_valid_i,
  output logic                          ack_o,
  output logic                          done_o,
  output logic [AXI_ID_WIDTH-1:0]       awid_o,
  output logic [AXI_ADDR_WIDTH-1:0]     awaddr_o,
  output logic [7:0]                    awlen_o,
  output logic [2:0]                    awsize_o,
  output logic [1:0]                    awburst_o,
  output logic                          awvalid_o,
  input  logic                          awready_i,
  output logic [AXI_DATA_WIDTH-1:0]     wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   wstrb_o,
  output logic                          wlast_o,
  output logic                          wvalid_o,
  input  logic                          wready_i,
  input  logic [AXI_ID_WIDTH-1:0]       bid_i,
  input  logic [1:0]                    bresp_i,
  input  logic                          bvalid_i,
  output logic                          bready_o,
  output logic                          err_o
);

  localparam int SIZE = clog2(AXI_DATA_WIDTH / 8);

  wr_state_e                     state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [7:0]                    len_q;
  logic [7:0]                    out_cnt_q;
  logic [8:0]                    in_cnt_q;
  logic                          ack_q, done_q, err_q;
  logic [2:0]                    awsize_q;
  logic [1:0]                    awburst_q;
  logic [AXI_ID_WIDTH-1:0]       awid_q;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q;

  logic                          awvalid, bready, in_data;
  logic                          req_take, aw_hs, w_hs, b_hs, beat_accept;
  logic                          fifo_empty, fifo_full;
  logic [AXI_DATA_WIDTH-1:0]     fifo_dout;

  assign req_take    = (state_q == ST_IDLE) && req_i && !done_q;
  assign aw_hs       = awvalid && awready_i;
  assign w_hs        = wvalid_o && wready_i;
  assign b_hs        = bready && bvalid_i;
  assign beat_accept = in_data && data_valid_i && !fifo_full && (in_cnt_q <= {1'b0, len_q});

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_take) state_d = ST_ADDR; else state_d = ST_IDLE;
      ST_ADDR: if (aw_hs) state_d = ST_DATA; else state_d = ST_ADDR;
      ST_DATA: if (w_hs && wlast_o) state_d = ST_RESP; else state_d = ST_DATA;
      ST_RESP: if (b_hs) state_d = ST_IDLE; else state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    awvalid = 1'b0;
    in_data = 1'b0;
    bready  = 1'b0;
    case (state_q)
      ST_ADDR: awvalid = 1'b1;
      ST_DATA: in_data = 1'b1;
      ST_RESP: bready  = 1'b1;
      default: awvalid = 1'b0;
    endcase
  end

  // Request capture, beat counters and the one-cycle ack/done pulses.
  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      addr_q    <= '0;
      len_q     <= 8'd0;
      in_cnt_q  <= 9'd0;
      out_cnt_q <= 8'd0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (req_take) begin
        addr_q    <= wstart_addr_i;
        len_q     <= burst_size_i;
        in_cnt_q  <= 9'd0;
        out_cnt_q <= 8'd0;
      end else begin
        if (beat_accept) in_cnt_q <= in_cnt_q + 9'd1;
        if (w_hs) out_cnt_q <= out_cnt_q + 8'd1;
      end
      ack_q  <= aw_hs;
      done_q <= b_hs;
    end
  end

  // Static AW/W fields read as zero while in reset.
  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      awsize_q  <= 3'd0;
      awburst_q <= 2'b00;
      awid_q    <= '0;
      wstrb_q   <= '0;
    end else begin
      awsize_q  <= 3'(SIZE);
      awburst_q <= AXI_BURST_INCR;
      awid_q    <= AXI_ID_WIDTH'(AXI_ID);
      wstrb_q   <= '1;
    end
  end

`ifdef AXI_WR_RESP_CHK_EN
  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if (b_hs && ((bresp_i != AXI_RESP_OKAY) || (bid_i != AXI_ID_WIDTH'(AXI_ID)))) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end
`else
  logic unused_b_chan;
  assign unused_b_chan = ^{bid_i, bresp_i};

  always_ff @(posedge sys_clk_i) begin
    err_q <= 1'b0;
  end
`endif

  ddr_wr_data_fifo #(
    .DW    (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk_i),
    .reset_i (reset_i),
    .push_i  (beat_accept),
    .din_i   (data_i),
    .pop_i   (w_hs),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign ack_o     = ack_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign awid_o    = awid_q;
  assign awaddr_o  = addr_q;
  assign awlen_o   = len_q;
  assign awsize_o  = awsize_q;
  assign awburst_o = awburst_q;
  assign awvalid_o = awvalid;
  assign bready_o  = bready;
  assign wstrb_o   = wstrb_q;
  assign wvalid_o  = !fifo_empty;
  assign wlast_o   = !fifo_empty && (out_cnt_q == len_q);
  assign wdata_o   = fifo_empty ? {AXI_DATA_WIDTH{1'b0}} : fifo_dout;

endmodule

// File: tb/tb_ddr_axi4_write_master.sv
// Self-checking bench for ddr_axi4_write_master: transaction-level expectations
// (AW records, ordered W beats, done pulses) checked against the DUT every cycle.
module tb_ddr_axi4_write_master;

  localparam int AW  = 32;
  localparam int DW  = 512;
  localparam int IDW = 4;

  logic            clk, rst, req, data_valid, awready, wready, bvalid;
  logic [AW-1:0]   wstart_addr;
  logic [7:0]      burst_size;
  logic [DW-1:0]   data;
  logic            ack, done, err, awvalid, wlast, wvalid, bready;
  logic [IDW-1:0]  awid, bid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst, bresp;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;

  typedef struct { logic [DW-1:0] d; logic last; } wbeat_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] l; } aw_t;

  wbeat_t     exp_w[$];
  aw_t        exp_aw[$];
  int         n_cmp, n_fail;
  int         done_seen, w_seen, last_seen, aw_hi_cycles, aw_hi_last;
  int         aw_delay;
  bit         w_toggle;
  logic [1:0] b_resp_val;
  logic       exp_err;

  ddr_axi4_write_master dut (
    .sys_clk_i(clk), .reset_i(rst), .req_i(req), .wstart_addr_i(wstart_addr),
    .burst_size_i(burst_size), .data_i(data), .data_valid_i(data_valid),
    .ack_o(ack), .done_o(done), .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen),
    .awsize_o(awsize), .awburst_o(awburst), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] beat_val(input logic [7:0] tag, input int idx);
    return {(DW/32){tag, 24'(idx)}};
  endfunction

  // AW slave: awready after aw_delay cycles of awvalid
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    awready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (awvalid) begin
        awready = (wait_cnt >= aw_delay);
        wait_cnt = awready ? 0 : wait_cnt + 1;
      end else begin
        awready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    wready = 1'b1;
    forever begin
      @(posedge clk); #1;
      wready = w_toggle ? ~wready : 1'b1;
    end
  end

  initial begin
    bvalid = 1'b0; bresp = 2'b00; bid = '0;
    forever begin
      @(posedge clk); #1;
      bvalid = bready;
      bresp  = b_resp_val;
      bid    = '0;
    end
  end

  // Per-cycle compare against the transaction model
  initial begin
    bit            prev_aw_hs, prev_b_hs, prev_aw_wait;
    logic [AW-1:0] prev_addr;
    logic [7:0]    prev_len;
    aw_t           a;
    wbeat_t        b;
    prev_aw_hs = 0; prev_b_hs = 0; prev_aw_wait = 0; prev_addr = '0; prev_len = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_aw_hs = 0; prev_b_hs = 0; prev_aw_wait = 0; aw_hi_cycles = 0;
      end else begin
        check("ack_timing", ack, prev_aw_hs);
        check("done_timing", done, prev_b_hs);
        if (prev_aw_wait) begin
          check("aw_hold_valid", awvalid, 1'b1);
          check("aw_hold_addr", awaddr, prev_addr);
          check("aw_hold_len", awlen, prev_len);
        end
        if (awvalid) begin
          aw_hi_cycles++;
          check("awsize", awsize, 3'd6);
          check("awburst", awburst, 2'b01);
          check("awid", awid, 4'd0);
        end
        if (wvalid) check("wstrb", wstrb, {(DW/8){1'b1}});
        if (awvalid && awready) begin
          aw_hi_last = aw_hi_cycles;
          aw_hi_cycles = 0;
          if (exp_aw.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL aw_extra: unexpected AW addr %0h", awaddr);
          end else begin
            a = exp_aw.pop_front();
            check("awaddr", awaddr, a.a);
            check("awlen", awlen, a.l);
          end
        end
        if (wvalid && wready) begin
          w_seen++;
          if (wlast) last_seen++;
          if (exp_w.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL w_extra: unexpected beat %0h", wdata[31:0]);
          end else begin
            b = exp_w.pop_front();
            check("wdata", wdata, b.d);
            check("wlast", wlast, b.last);
          end
        end
        if (done) done_seen++;
        prev_aw_hs   = awvalid && awready;
        prev_b_hs    = bvalid && bready;
        prev_aw_wait = awvalid && !awready;
        prev_addr    = awaddr;
        prev_len     = awlen;
      end
    end
  end

  task automatic issue_req(input logic [AW-1:0] addr, input logic [7:0] len, input int pre_junk);
    aw_t t;
    int  k;
    @(posedge clk); #1;
    req = 1'b1; wstart_addr = addr; burst_size = len;
    t.a = addr; t.l = len;
    exp_aw.push_back(t);
    if (pre_junk != 0) begin
      data_valid = 1'b1;
      data = {(DW/32){32'hDEAD_BEEF}};
    end
    @(posedge clk); #1;
    check("req_to_awvalid", awvalid, 1'b1);
    k = 0;
    while (!ack && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("ack_seen", ack, 1'b1);
    req = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic run_burst(input logic [AW-1:0] addr, input logic [7:0] len, input int nbeats,
                           input int pre_junk, input logic [7:0] tag);
    int     start_done, k;
    wbeat_t b;
    start_done = done_seen;
    issue_req(addr, len, pre_junk);
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk); #1;
      data_valid = 1'b1;
      data = beat_val(tag, i);
      if (i <= int'(len)) begin
        b.d = data; b.last = (i == int'(len));
        exp_w.push_back(b);
      end
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    k = 0;
    while (done_seen == start_done && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_count", done_seen - start_done, 1);
    check("w_all_sent", exp_w.size(), 0);
  endtask

  initial begin
    int     w0, l0, i;
    wbeat_t b;
    n_cmp = 0; n_fail = 0; done_seen = 0; w_seen = 0; last_seen = 0;
    aw_hi_cycles = 0; aw_hi_last = 0; aw_delay = 0; w_toggle = 0; b_resp_val = 2'b00;
    exp_err = 1'b0;
    rst = 1'b1; req = 1'b0; data_valid = 1'b0; wstart_addr = '0; burst_size = '0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_awsize", awsize, 3'd0);
    check("rst_wdata", wdata, '0);
    rst = 1'b0;

    // 1: single beat, immediate handshakes
    w0 = w_seen; l0 = last_seen;
    run_burst(32'h1000_0000, 8'd0, 1, 0, 8'h01);
    check("t1_beats", w_seen - w0, 1);
    check("t1_lasts", last_seen - l0, 1);

    // 2: maximum burst with 50% wready
    w_toggle = 1'b1;
    w0 = w_seen; l0 = last_seen;
    run_burst(32'h1000_1000, 8'd255, 256, 0, 8'h02);
    check("t2_beats", w_seen - w0, 256);
    check("t2_lasts", last_seen - l0, 1);
    w_toggle = 1'b0;

    // 3: awready stalled 10 cycles, early beats must be dropped
    aw_delay = 10;
    w0 = w_seen;
    run_burst(32'h1000_2000, 8'd3, 4, 1, 8'h03);
    check("t3_aw_cycles", aw_hi_last, 11);
    check("t3_beats", w_seen - w0, 4);
    aw_delay = 0;

    // 4: surplus beats dropped, next burst clean
    w0 = w_seen;
    run_burst(32'h1000_3000, 8'd3, 6, 0, 8'h04);
    check("t4_beats", w_seen - w0, 4);
    w0 = w_seen;
    run_burst(32'h1000_4000, 8'd1, 2, 0, 8'h05);
    check("t4_next_beats", w_seen - w0, 2);

    // 5: reset after the second W beat of an 8-beat burst
    w0 = w_seen;
    issue_req(32'h2000_0000, 8'd7, 0);
    i = 0;
    while (i < 8 && (w_seen - w0) < 2) begin
      @(posedge clk); #1;
      if ((w_seen - w0) < 2) begin
        data_valid = 1'b1;
        data = beat_val(8'h55, i);
        b.d = data; b.last = (i == 7);
        exp_w.push_back(b);
        i++;
      end
    end
    rst = 1'b1;
    data_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_w.delete();
    exp_aw.delete();
    check("t5_beats_before_rst", w_seen - w0, 2);
    check("t5_awvalid", awvalid, 1'b0);
    check("t5_wvalid", wvalid, 1'b0);
    check("t5_bready", bready, 1'b0);
    check("t5_ack", ack, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_fifo_flushed", wvalid, 1'b0);
    run_burst(32'h1000_5000, 8'd2, 3, 0, 8'h06);

    // 6: error response handling
    b_resp_val = 2'b10;
`ifdef AXI_WR_RESP_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_burst(32'h1000_6000, 8'd0, 1, 0, 8'h07);
    check("t6_err_slverr", err, exp_err);
    b_resp_val = 2'b00;
    run_burst(32'h1000_7000, 8'd1, 2, 0, 8'h08);
    check("t6_err_sticky", err, exp_err);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_err_cleared", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
